mem_access_bridge: RTL

- Registered request/response bridge between the core's memory port and the memory block's rd/wr/ack interface.
- Captures one core access at a time and drives the memory with a single-cycle enable pulse.
- Waits for the memory ack, then returns read data or write completion to the core with a one-cycle valid pulse.
- Decouples core timing from memory latency and gives the core an explicit busy/stall signal.

---
 rtl/mem_access_bridge.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_access_bridge.sv
// Registered core-to-memory bridge: one access in flight, single-cycle memory enable, one-cycle valid back.
// Optional ack timeout enabled by defining MEM_BRIDGE_TIMEOUT_EN.
module mem_access_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_rd_en_i,
  input  logic                  core_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] core_addr_i,
  input  logic [DATA_WIDTH-1:0] core_data_i,
  output logic [DATA_WIDTH-1:0] core_data_o,
  output logic                  core_valid_o,
  output logic                  core_busy_o,
  output logic                  mem_rd_en_o,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_ack_i,
  output logic                  err_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic                  is_wr_q, is_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  valid_q, valid_d;
  logic                  rd_en_q, rd_en_d;
  logic                  wr_en_q, wr_en_d;
  logic                  err_q, err_d;

  // Byte offset bits are dropped by word alignment.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^core_addr_i[1:0];

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    rd_en_d = 1'b0;
    wr_en_d = 1'b0;
    err_d   = 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (core_wr_en_i || core_rd_en_i) begin
          state_d = REQ;
          is_wr_d = core_wr_en_i;
          addr_d  = {core_addr_i[ADDR_WIDTH-1:2], 2'b00};
          wdata_d = core_data_i;
          rd_en_d = ~core_wr_en_i;
          wr_en_d = core_wr_en_i;
`ifdef MEM_BRIDGE_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      REQ, WAIT: begin
        if (mem_ack_i) begin
          state_d = RESP;
          valid_d = 1'b1;
          if (!is_wr_q) rdata_d = mem_data_i;
        end else begin
          state_d = WAIT;
`ifdef MEM_BRIDGE_TIMEOUT_EN
          // Limit reached after TIMEOUT_CYCLES ack-less cycles in REQ/WAIT.
          if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_d = RESP;
            valid_d = 1'b1;
            err_d   = 1'b1;
            if (!is_wr_q) rdata_d = '1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`endif
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      err_q   <= err_d;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign core_busy_o  = (state_q != IDLE);
  assign core_valid_o = valid_q;
  assign core_data_o  = rdata_q;
  assign mem_rd_en_o  = rd_en_q;
  assign mem_wr_en_o  = wr_en_q;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = wdata_q;
`ifdef MEM_BRIDGE_TIMEOUT_EN
  assign err_o        = err_q;
`else
  assign err_o        = 1'b0;
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule
